ro_demux_rx: RTL and testbench

- Receive end of the shared readout bus. Takes the time-multiplexed `out_mux_pol` / `out_mux_pol_eve` lines driven by the `ro_block_1` bank.
- Takes the low `N_CH` bits of the shared `gray_count` value.
- Decodes which channel owns each gray tick. In gray code exactly one bit toggles per tick; bit i toggling means channel i owns the bus.
- Rebuilds per-channel polarity state and streams `{channel, pol, pol_eve}` records through a small ready/valid FIFO to downstream logic.

---
 rtl/ro_pkg.sv | 22 ++
 rtl/ro_rec_fifo.sv | 61 ++++++
 rtl/ro_demux_rx.sv | 134 +++++++++++++
 tb/tb_ro_demux_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// Shared readout-bus types: default channel count, head record layout and a
// one-hot to index helper used by the receive demultiplexer.
package ro_pkg;

  localparam int RO_N_CH = 8;
  localparam int RO_CH_W = $clog2(RO_N_CH);

  typedef struct packed {
    logic [RO_CH_W-1:0] ch;
    logic               pol;
    logic               pol_eve;
  } ro_rec_t;

  // Caller guarantees at most one bit set; with none set the result is 0.
  function automatic int onehot_to_idx(input logic [31:0] v);
    onehot_to_idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) onehot_to_idx = i;
    end
  endfunction

endpackage

// File: rtl/ro_rec_fifo.sv
// Small synchronous ready/valid record FIFO; a push on a full FIFO with no
// simultaneous pop is dropped and flagged for one cycle on drop.
module ro_rec_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [W-1:0]  last_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop     = !empty && ready;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  assign valid = !empty;
  assign dout  = empty ? last_q : mem[rd_ptr];

  // NOTE: the storage array is reset along with the pointers so the head
  // outputs are a defined 0 after reset rather than whatever the RAM holds.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      last_q <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ro_demux_rx.sv
// Readout-bus receiver: decodes channel ownership from single-bit gray changes
// and streams {ch, pol, pol_eve} records. RO_EDGE_COUNT_EN adds ev_cnt counters.
module ro_demux_rx
  import ro_pkg::*;
#(
  parameter int N_CH       = RO_N_CH,
  parameter int CH_W       = $clog2(N_CH),
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              en,
  input  logic [N_CH-1:0]   gray,
  input  logic              in_mux_pol,
  input  logic              in_mux_pol_eve,
  input  logic              out_ready,
  input  logic              clr_err,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_pol,
  output logic              out_pol_eve,
  output logic [N_CH-1:0]   ch_pol,
  output logic [N_CH-1:0]   ch_pol_eve,
  output logic              frame_done,
  output logic              err_multi,
  output logic              err_ovf
`ifdef RO_EDGE_COUNT_EN
  ,
  output logic [N_CH*CNT_W-1:0] ev_cnt
`endif
);

  logic [N_CH-1:0] g_q, g_qq, seen, diff, seen_nxt;
  logic            p_q, e_q, sampled, primed;
  logic            active, multi, slot, drop;
  logic [CH_W-1:0] slot_idx;
  ro_rec_t         push_rec, head_rec;

  // NOTE: registers use non-blocking assignments so every stage samples the
  // previous-cycle value of the stage before it.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      g_q     <= '0;
      g_qq    <= '0;
      p_q     <= 1'b0;
      e_q     <= 1'b0;
      sampled <= 1'b0;
      primed  <= 1'b0;
    end else begin
      g_q     <= gray;
      g_qq    <= g_q;
      p_q     <= in_mux_pol;
      e_q     <= in_mux_pol_eve;
      sampled <= 1'b1;
      primed  <= sampled;
    end
  end

  // NOTE: every output of this block gets a default first so no latch forms.
  always_comb begin
    diff     = g_q ^ g_qq;
    active   = en && primed;
    multi    = |(diff & (diff - 1'b1));
    slot     = active && (diff != '0) && !multi;
    slot_idx = CH_W'(onehot_to_idx(32'(diff)));
    seen_nxt = seen | diff;
    push_rec = '{ch: slot_idx, pol: p_q, pol_eve: e_q};
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ch_pol     <= '0;
      ch_pol_eve <= '0;
      seen       <= '0;
      frame_done <= 1'b0;
      err_multi  <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (slot) begin
        ch_pol[slot_idx]     <= p_q;
        ch_pol_eve[slot_idx] <= e_q;
        if (seen_nxt == '1) begin
          seen       <= '0;
          frame_done <= 1'b1;
        end else begin
          seen <= seen_nxt;
        end
      end
      // Set wins over a same-cycle clear.
      if (active && multi) err_multi <= 1'b1;
      else if (clr_err)    err_multi <= 1'b0;
      if (drop)            err_ovf   <= 1'b1;
      else if (clr_err)    err_ovf   <= 1'b0;
    end
  end

  ro_rec_fifo #(
    .W     ($bits(ro_rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (slot),
    .din   (push_rec),
    .ready (out_ready),
    .valid (out_valid),
    .dout  (head_rec),
    .drop  (drop)
  );

  assign out_ch      = head_rec.ch;
  assign out_pol     = head_rec.pol;
  assign out_pol_eve = head_rec.pol_eve;

`ifdef RO_EDGE_COUNT_EN
  logic [CNT_W-1:0] cnt [N_CH];

  // Rising edge is judged against the stored state before this commit.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else if (slot && p_q && !ch_pol[slot_idx]) begin
      cnt[slot_idx] <= cnt[slot_idx] + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ev
    assign ev_cnt[k*CNT_W +: CNT_W] = cnt[k];
  end
`endif

endmodule

// File: tb/tb_ro_demux_rx.sv
// Scoreboard bench for ro_demux_rx: directed gray sequences push expected
// records; an independent monitor pops and compares on each accepted beat.
module tb_ro_demux_rx;

  localparam int N_CH  = 8;
  localparam int CH_W  = 3;
  localparam int CNT_W = 8;
  localparam int RW    = CH_W + 2;

  logic            clk = 1'b0;
  logic            rstb, en, in_mux_pol, in_mux_pol_eve, out_ready, clr_err;
  logic [N_CH-1:0] gray;
  logic            out_valid, out_pol, out_pol_eve, frame_done, err_multi, err_ovf;
  logic [CH_W-1:0] out_ch;
  logic [N_CH-1:0] ch_pol, ch_pol_eve;
`ifdef RO_EDGE_COUNT_EN
  logic [N_CH*CNT_W-1:0] ev_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [RW-1:0] exp_q[$];
  int fd_at[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ro_demux_rx dut (
    .clk            (clk),
    .rstb           (rstb),
    .en             (en),
    .gray           (gray),
    .in_mux_pol     (in_mux_pol),
    .in_mux_pol_eve (in_mux_pol_eve),
    .out_ready      (out_ready),
    .clr_err        (clr_err),
    .out_valid      (out_valid),
    .out_ch         (out_ch),
    .out_pol        (out_pol),
    .out_pol_eve    (out_pol_eve),
    .ch_pol         (ch_pol),
    .ch_pol_eve     (ch_pol_eve),
    .frame_done     (frame_done),
    .err_multi      (err_multi),
    .err_ovf        (err_ovf)
`ifdef RO_EDGE_COUNT_EN
    ,
    .ev_cnt         (ev_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares each accepted head record against the scoreboard.
  always @(negedge clk) begin
    if (rstb === 1'b1 && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rec_unexpected: got 0x%0h, required no record", {out_ch, out_pol, out_pol_eve});
      end else begin
        check("rec", {out_ch, out_pol, out_pol_eve}, exp_q.pop_front());
      end
    end
    if (rstb === 1'b1 && frame_done) fd_at.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] g8(input int b);
    int m;
    m = b & 255;
    return 8'(m ^ (m >> 1));
  endfunction

  // Owning channel for binary tick b of an 8-bit gray counter.
  function automatic int owner(input int b);
    if ((b & 255) == 0) return 7;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) == 1) return i;
    return 0;
  endfunction

  task automatic drive(input logic [7:0] g, input logic p, input logic e);
    @(posedge clk);
    #1;
    gray           = g;
    in_mux_pol     = p;
    in_mux_pol_eve = e;
  endtask

  task automatic slot(input logic [7:0] g, input int ch, input logic p, input logic e, input bit pushed);
    drive(g, p, e);
    if (pushed) exp_q.push_back({3'(ch), p, e});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rstb           = 1'b0;
    gray           = '0;
    in_mux_pol     = 1'b0;
    in_mux_pol_eve = 1'b0;
    clr_err        = 1'b0;
    out_ready      = 1'b1;
    exp_q.delete();
    idle(2);
    rstb = 1'b1;
    idle(3);
  endtask

  initial begin
    logic [2:0] chv;
    logic [7:0] g;
    int c128, c256;
    logic [7:0] ov_g [6] = '{8'h0D, 8'h0F, 8'h0B, 8'h03, 8'h13, 8'h33};
    logic       ov_p [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic       ov_e [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    c128 = 0;
    c256 = 0;

    en = 1'b1;
    rstb = 1'b0;
    gray = '0;
    in_mux_pol = 1'b0;
    in_mux_pol_eve = 1'b0;
    out_ready = 1'b1;
    clr_err = 1'b0;
    #12;
    check("reset_outs", {out_valid, out_ch, out_pol, out_pol_eve, ch_pol, ch_pol_eve,
                         frame_done, err_multi, err_ovf}, 32'h0);
    @(posedge clk);
    #1 rstb = 1'b1;
    idle(3);

    // First change: visible on out_valid at the third edge after it is driven.
    slot(g8(1), 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk) check("lat_edge1", out_valid, 0);
    @(negedge clk) check("lat_edge2", out_valid, 0);
    @(negedge clk) check("lat_edge3", out_valid, 1);

    // Full 8-bit gray count; pol = channel parity, pol_eve = channel bit 1.
    for (int b = 2; b <= 256; b++) begin
      chv = 3'(owner(b));
      slot(g8(b), int'(chv), ^chv, chv[1], 1'b1);
      if (b == 128) c128 = cyc;
      if (b == 256) c256 = cyc;
    end
    idle(4);
    check("fd_count", fd_at.size(), 2);
    check("fd_first", (fd_at.size() > 0) ? fd_at[0] : -1, c128 + 2);
    check("fd_second", (fd_at.size() > 1) ? fd_at[1] : -1, c256 + 2);
    check("stream_err_multi", err_multi, 0);
    check("stream_ch_pol", ch_pol, 8'h96);
    check("stream_ch_pol_eve", ch_pol_eve, 8'hCC);
    check("stream_drained", exp_q.size(), 0);

    // Two bits change in one tick.
    slot(8'h03, 0, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("multi_set", err_multi, 1);
    check("multi_no_rec", out_valid, 0);
    pulse_clr();
    @(negedge clk) check("multi_clr", err_multi, 0);
    drive(8'h0C, 1'b0, 1'b0);
    @(posedge clk);
    #1 clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    @(negedge clk) check("multi_set_wins", err_multi, 1);
    check("ovf_clear_before", err_ovf, 0);

    // Overflow: six slots into a depth-4 FIFO with the sink stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) slot(ov_g[i], i, ov_p[i], ov_e[i], i < 4);
    idle(4);
    check("ovf_set", err_ovf, 1);
    check("ovf_held", out_valid, 1);
    check("ovf_ch_pol", ch_pol, 8'hAD);
    check("ovf_ch_pol_eve", ch_pol_eve, 8'hE6);
    out_ready = 1'b1;
    idle(6);
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_empty", out_valid, 0);
    check("empty_holds_last", {out_ch, out_pol, out_pol_eve}, {3'd3, 1'b1, 1'b0});
    pulse_clr();
    @(negedge clk) check("ovf_clr", err_ovf, 0);

    // Asynchronous reset with three records queued.
    out_ready = 1'b0;
    slot(8'h73, 6, 1'b0, 1'b1, 1'b1);
    slot(8'hF3, 7, 1'b1, 1'b1, 1'b1);
    slot(8'hF2, 0, 1'b0, 1'b0, 1'b1);
    idle(3);
    check("rst_pre_valid", out_valid, 1);
    #2 rstb = 1'b0;
    #1;
    check("rst_async_outs", {out_valid, out_ch, out_pol, out_pol_eve, ch_pol, ch_pol_eve,
                             frame_done, err_multi, err_ovf}, 32'h0);
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk) rstb = 1'b1;
    idle(4);
    check("rst_no_false_rec", out_valid, 0);
    check("rst_no_false_err", err_multi, 0);
    slot(8'hF0, 1, 1'b1, 1'b0, 1'b1);
    idle(4);
    check("rst_first_real", exp_q.size(), 0);
    check("rst_ch_pol", ch_pol, 8'h02);

`ifdef RO_EDGE_COUNT_EN
    do_reset();
    check("cnt_reset", ev_cnt[7:0], 0);
    g = '0;
    for (int i = 0; i < 5; i++) begin
      g ^= 8'h01;
      slot(g, 0, (i == 1 || i == 2 || i == 4), 1'b0, 1'b1);
    end
    idle(4);
    check("cnt_pattern", ev_cnt[7:0], 2);
    do_reset();
    g = '0;
    for (int i = 0; i < 600; i++) begin
      g ^= 8'h01;
      slot(g, 0, 1'(i & 1), 1'b0, 1'b1);
    end
    idle(4);
    check("cnt_wrap", ev_cnt[7:0], 44);
    check("cnt_other_ch", ev_cnt[15:8], 0);
    check("cnt_drained", exp_q.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
